// File: rtl/cgol_frame_sequencer.sv
// Game-of-Life LED frame sequencer: streams cell states to a WS2812B driver,
// latches the frame, holds it on display, then requests the next generation.
module cgol_frame_sequencer #(
  parameter int unsigned NUM_PIXELS     = 64,
  parameter logic [23:0] ALIVE_COLOR    = 24'h001000,
  parameter logic [23:0] DEAD_COLOR     = 24'h000000,
  parameter int unsigned LATCH_CYCLES   = 600,
  parameter int unsigned HOLD_CYCLES    = 6000000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  localparam int unsigned AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_run,
  output logic          cgol_start,
  input  logic          cgol_done,
  output logic          mem_sel,
  output logic          pix_rd,
  output logic [AW-1:0] pix_addr,
  input  logic          pix_alive,
  output logic          ws_load,
  output logic [23:0]   ws_color,
  output logic          ws_transmit,
  input  logic          ws_pixel_done,
  output logic          busy,
  output logic          o_error,
  output logic [15:0]   frame_count
);

  localparam int unsigned CMAX_LH = (LATCH_CYCLES > HOLD_CYCLES) ? LATCH_CYCLES : HOLD_CYCLES;
  localparam int unsigned CMAX    = (CMAX_LH > TIMEOUT_CYCLES) ? CMAX_LH : TIMEOUT_CYCLES;
  localparam int unsigned CW      = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_DATA, SEND, LATCH, HOLD, COMPUTE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] index_q, index_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [23:0]   color_q, color_d;
  logic [15:0]   frame_cnt_q;
  logic [15:0]   frame_cnt_d;
  logic          frame_inc;
  logic          start_block_q;
  logic          cgol_start_q, mem_sel_q, pix_rd_q, ws_load_q, ws_transmit_q, busy_q;

  assign frame_cnt_d = frame_inc ? frame_cnt_q + 16'd1 : frame_cnt_q;

  // Next-state logic; one shared counter serves LATCH, HOLD and COMPUTE timing
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    color_d   = color_q;
    frame_inc = 1'b0;
    case (state_q)
      IDLE: begin
        // start_block_q keeps the first cycle out of reset quiet
        if (i_run && !err_q && !start_block_q) begin
          state_d = FETCH;
          index_d = '0;
        end
      end
      FETCH: state_d = WAIT_DATA;
      WAIT_DATA: begin
        color_d = pix_alive ? ALIVE_COLOR : DEAD_COLOR;
        state_d = SEND;
      end
      SEND: begin
        if (ws_pixel_done) begin
          if (index_q == AW'(NUM_PIXELS - 1)) begin
            index_d = '0;
            cnt_d   = '0;
            state_d = LATCH;
          end else begin
            index_d = index_q + AW'(1);
            state_d = FETCH;
          end
        end
      end
      LATCH: begin
        if (cnt_q == CW'(LATCH_CYCLES - 1)) begin
          cnt_d     = '0;
          frame_inc = 1'b1;
          state_d   = HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = i_run ? COMPUTE : IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      COMPUTE: begin
        // A done arriving on the final timeout cycle still wins
        if (cgol_done) begin
          cnt_d   = '0;
          index_d = '0;
          state_d = FETCH;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, derived from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      index_q       <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      color_q       <= '0;
      frame_cnt_q   <= '0;
      start_block_q <= 1'b1;
      cgol_start_q  <= 1'b0;
      mem_sel_q     <= 1'b0;
      pix_rd_q      <= 1'b0;
      ws_load_q     <= 1'b0;
      ws_transmit_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      color_q       <= color_d;
      frame_cnt_q   <= frame_cnt_d;
      start_block_q <= 1'b0;
      cgol_start_q  <= (state_d == COMPUTE) && (state_q != COMPUTE);
      mem_sel_q     <= (state_d == FETCH) || (state_d == WAIT_DATA) || (state_d == SEND);
      pix_rd_q      <= (state_d == FETCH);
      ws_load_q     <= (state_d == SEND) && (state_q == WAIT_DATA);
      ws_transmit_q <= (state_d == SEND);
      busy_q        <= (state_d != IDLE);
    end
  end

  assign cgol_start  = cgol_start_q;
  assign mem_sel     = mem_sel_q;
  assign pix_rd      = pix_rd_q;
  assign pix_addr    = index_q;
  assign ws_load     = ws_load_q;
  assign ws_color    = color_q;
  assign ws_transmit = ws_transmit_q;
  assign busy        = busy_q;
  assign o_error     = err_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: doc/cgol_frame_sequencer.md
CGOL_FRAME_SEQUENCER -- requirements
Module: cgol_frame_sequencer

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 64, number of LED matrix cells per frame.
REQ-002 SHALL have parameter ALIVE_COLOR, default 24'h001000, GRB word for a living cell.
REQ-003 SHALL have parameter DEAD_COLOR, default 24'h000000, GRB word for a dead cell.
REQ-004 SHALL have parameter LATCH_CYCLES, default 600, WS2812B reset-latch low time in clk cycles.
REQ-005 SHALL have parameter HOLD_CYCLES, default 6000000, frame display hold time in clk cycles.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum wait for cgol_done.
REQ-007 SHALL have ports, with one clock and a synchronous active-high reset:
  clk  input  1  system clock, all logic on rising edge
  rst  input  1  synchronous active-high reset
  i_run  input  1  user run level (SW)
  cgol_start  output  1  one-cycle start pulse to generation logic
  cgol_done  input  1  one-cycle generation-complete pulse
  mem_sel  output  1  cell-memory port owner: 1 = sequencer, 0 = generation logic
  pix_rd  output  1  one-cycle cell read strobe
  pix_addr  output  clog2(NUM_PIXELS)  cell read address
  pix_alive  input  1  cell state, valid the cycle after pix_rd
  ws_load  output  1  one-cycle load of ws_color into driver shift register
  ws_color  output  24  GRB word for current pixel
  ws_transmit  output  1  driver enable
  ws_pixel_done  input  1  one-cycle pulse, 24 bits shifted out
  busy  output  1  state != IDLE
  o_error  output  1  sticky generation-timeout flag
  frame_count  output  16  frames latched to the matrix

Function
REQ-008 SHALL implement states IDLE, FETCH, WAIT_DATA, SEND, LATCH, HOLD, COMPUTE.
REQ-009 IDLE: when i_run=1 and o_error=0 -> FETCH with pixel index 0 (seed frame is displayed before the first generation).
REQ-010 FETCH: pix_rd=1, pix_addr=index, for exactly one cycle -> WAIT_DATA.
REQ-011 WAIT_DATA: register ws_color = pix_alive ? ALIVE_COLOR : DEAD_COLOR, pulse ws_load in the same cycle -> SEND.
REQ-012 SEND: ws_transmit=1 held; on ws_pixel_done: index==NUM_PIXELS-1 -> index=0, LATCH; otherwise index+1, FETCH.
REQ-013 LATCH: ws_transmit=0 for exactly LATCH_CYCLES cycles; on exit frame_count increments (16-bit wrap 16'hFFFF->0) -> HOLD.
REQ-014 HOLD: stay exactly HOLD_CYCLES cycles; at end i_run=1 -> COMPUTE, i_run=0 -> IDLE.
REQ-015 COMPUTE: cgol_start pulses high only on the first cycle in the state; on cgol_done -> FETCH, index 0.
REQ-016 COMPUTE: if TIMEOUT_CYCLES cycles elapse without cgol_done, set o_error=1 -> IDLE; o_error cleared only by rst; IDLE does not restart while o_error=1.
REQ-017 mem_sel SHALL be 1 in FETCH, WAIT_DATA, SEND and 0 in all other states; pix_rd never asserts while mem_sel=0.
REQ-018 i_run SHALL be sampled only in IDLE and on the last HOLD cycle; deasserting mid-frame completes the frame.
REQ-019 cgol_done outside COMPUTE and ws_pixel_done outside SEND SHALL be ignored.
REQ-020 cgol_done coincident with the timeout cycle SHALL take priority (-> FETCH, no error).
REQ-021 ws_load, cgol_start and pix_rd SHALL be single-cycle pulses, never asserted together.

Reset
REQ-022 On rst=1 at a clock edge: state IDLE; index, all counters, frame_count, o_error = 0; ws_color = 24'h0; all pulse outputs, ws_transmit, mem_sel, busy = 0; no pulse SHALL issue in the cycle after rst deasserts.
REQ-023 rst asserted in any state, including mid-SEND, SHALL abort immediately with the REQ-022 values.

Verification (NUM_PIXELS=4, LATCH_CYCLES=3, HOLD_CYCLES=5, TIMEOUT_CYCLES=20)
REQ-024 Seed frame: rst, i_run=1, pix_alive pattern 1,0,0,1, ws_pixel_done 2 cycles after each ws_load -> ws_color 001000,000000,000000,001000; pix_addr 0..3; ws_transmit low 3 cycles; frame_count=1.
REQ-025 Generation: after HOLD (5 cycles) with i_run=1 -> single cgol_start pulse, mem_sel=0; cgol_done 7 cycles later -> pix_rd with pix_addr=0 the next cycle.
REQ-026 Stop: i_run dropped during SEND of pixel 1 -> frame completes, frame_count increments, IDLE after HOLD, busy=0, no cgol_start.
REQ-027 Timeout: cgol_done withheld -> o_error=1 after 20 COMPUTE cycles, IDLE, i_run=1 ignored until rst; separately cgol_done on cycle 20 -> no error.
REQ-028 Reset mid-SEND pixel 2 -> next cycle all outputs 0, frame_count=0; restart displays from pix_addr 0.
REQ-029 Wrap: frame_count forced to 16'hFFFF, one frame -> 16'h0000; spurious cgol_done/ws_pixel_done in IDLE and HOLD -> no state change.
